thread_scheduler: RTL and testbench
===================================

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 The block SHALL have parameter T0_START, default 16'h0000: reset PC of thread 0.
REQ-002 The block SHALL have parameter T1_START, default 16'h0001: reset PC of thread 1.
REQ-003 The block SHALL have parameter PC_STEP, default 16'h0002: PC increment per issued fetch.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  pipeline cannot accept a fetch this cycle.
REQ-007 halt_req  input  1  halt the thread named by halt_tid.
REQ-008 halt_tid  input  1  thread id for halt_req.
REQ-009 redir_valid  input  1  load a new PC into the thread named by redir_tid (jump, call, ret).
REQ-010 redir_tid  input  1  thread id for redir_valid.
REQ-011 redir_pc  input  16  target PC for the redirect.
REQ-012 fetch_valid  output  1  fetch_pc is issued this cycle.
REQ-013 fetch_tid  output  1  thread owning the issued fetch.
REQ-014 fetch_pc  output  16  instruction-memory address for the fetch.
REQ-015 halted  output  2  per-thread halted flags; bit n is thread n.
REQ-016 halt  output  1  all threads halted.

Function
REQ-017 Per-thread state SHALL be RUN or HALTED; RUN->HALTED on a halt_req edge for that thread; HALTED is exited only by reset.
REQ-018 A thread SHALL be eligible in a cycle when it is RUN, halt_req does not target it, and redir_valid does not target it.
REQ-019 Selection SHALL alternate strictly: prefer the thread other than last_tid; if that thread is ineligible, pick last_tid if it is eligible.
REQ-020 fetch_valid SHALL be 1 exactly when reset=0, stall=0, and at least one thread is eligible; fetch_tid and fetch_pc SHALL come combinationally from registered state with zero-cycle latency.
REQ-021 When fetch_valid=0, fetch_tid SHALL hold last_tid and fetch_pc SHALL be pc[last_tid].
REQ-022 On an edge with fetch_valid=1: pc[fetch_tid] <= pc[fetch_tid] + PC_STEP, modulo 2^16 (16'hFFFE + 2 = 16'h0000), and last_tid <= fetch_tid.
REQ-023 On an edge with redir_valid=1 and the target in RUN: pc[redir_tid] <= redir_pc, and last_tid SHALL not change because of the redirect.
REQ-024 A redirect targeting a HALTED thread, or a thread halted in the same cycle, SHALL be ignored; halt wins.
REQ-025 Simultaneous halt_req and redir_valid to different threads SHALL both take effect.
REQ-026 stall=1 SHALL block issue and the PC increment only; halt_req and redir_valid SHALL still take effect on that edge.
REQ-027 halt SHALL equal halted[0] & halted[1] and SHALL be derived from registered state only.

Reset
REQ-028 On a reset=1 edge: pc[0]<=T0_START, pc[1]<=T1_START, halted<=2'b00, last_tid<=1 so that thread 0 issues first.
REQ-029 While reset=1: fetch_valid=0 and halt=0; halt_req and redir_valid SHALL be ignored.
REQ-030 Reset mid-operation SHALL discard all PC, halt, and arbitration state with no residue.

Structure
REQ-031 WORD width (16), thread-id width (1), and thread count (2) SHALL be shared constants in the common defines package, alongside the opcode definitions.
REQ-032 Per-thread PC and RUN/HALTED state SHALL be implemented in one sub-module, sched_thread_ctx, instantiated twice.
REQ-033 Arbitration and output muxing SHALL reside in thread_scheduler.

Verification
REQ-034 Reset, then 4 cycles with stall=0 -> fetch (tid,pc): (0,0000), (1,0001), (0,0002), (1,0003).
REQ-035 halt_req for tid 0 in cycle 2 -> cycle 2 issues tid 1; thereafter only tid 1 issues with pc +2 per cycle; halted=01; halt=0.
REQ-036 redir_valid for tid 1 with redir_pc=0x0040, in a cycle where thread 1 is preferred -> tid 0 issues that cycle; the next tid-1 fetch is at 0x0040.
REQ-037 stall=1 for 3 cycles with halt_req for tid 1 during the stall -> fetch_valid=0 and PCs frozen throughout; halted=10 after the edge; on release only tid 0 issues.
REQ-038 pc[0]=0xFFFE (via redirect), then an issue -> next tid-0 fetch at 0x0000; halting both threads -> halt=1 the cycle after the second halt edge; reset asserted -> PCs restored and halt=0.

Source files
------------

// File: rtl/thread_scheduler_pkg.sv
// Shared constants and types for the two-thread fetch scheduler and the core
// that consumes its fetch stream.
package thread_scheduler_pkg;

  localparam int WORD_W      = 16;
  localparam int TID_W       = 1;
  localparam int NUM_THREADS = 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [TID_W-1:0]  tid_t;

  typedef enum logic {
    TS_RUN    = 1'b0,
    TS_HALTED = 1'b1
  } thread_state_e;

  // Instruction opcodes; JMP/CALL/RET are what raise redir_valid, HALT raises halt_req.
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ALU  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JMP  = 4'h4,
    OP_BR   = 4'h5,
    OP_CALL = 4'h6,
    OP_RET  = 4'h7,
    OP_HALT = 4'hF
  } opcode_e;

  function automatic tid_t other_tid(input tid_t t);
    return ~t;
  endfunction

endpackage

// File: rtl/sched_thread_ctx.sv
// Per-thread context: program counter plus RUN/HALTED state. HALTED is sticky
// until reset; a halt arriving with a redirect on the same edge wins.
module sched_thread_ctx
  import thread_scheduler_pkg::*;
#(
  parameter word_t START_PC = 16'h0000,
  parameter word_t PC_STEP  = 16'h0002
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  halt_set,
  input  logic  redir_set,
  input  word_t redir_pc,
  input  logic  issue,
  output word_t pc,
  output logic  halted
);

  thread_state_e state_q, state_d;
  word_t         pc_q, pc_d;

  // Modulo-2^16 advance; the carry out of the top bit is intentionally dropped.
  function automatic word_t pc_advance(input word_t cur);
    return cur + PC_STEP;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      TS_RUN: begin
        if (halt_set) begin
          state_d = TS_HALTED;
        end else if (redir_set) begin
          pc_d = redir_pc;
        end
        if (issue && !halt_set && !redir_set) begin
          pc_d = pc_advance(pc_q);
        end
      end
      TS_HALTED: begin
        state_d = TS_HALTED;
      end
      default: begin
        state_d = TS_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TS_RUN;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == TS_HALTED);

endmodule

// File: rtl/thread_scheduler.sv
// Two-thread fetch scheduler: strict alternation between eligible threads,
// with per-thread halt and redirect, issuing one fetch PC per cycle.
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter word_t T0_START = 16'h0000,
  parameter word_t T1_START = 16'h0001,
  parameter word_t PC_STEP  = 16'h0002
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   halt_req,
  input  tid_t                   halt_tid,
  input  logic                   redir_valid,
  input  tid_t                   redir_tid,
  input  word_t                  redir_pc,
  output logic                   fetch_valid,
  output tid_t                   fetch_tid,
  output word_t                  fetch_pc,
  output logic [NUM_THREADS-1:0] halted,
  output logic                   halt
);

  word_t                  pc_q [NUM_THREADS];
  logic [NUM_THREADS-1:0] halted_q;
  logic [NUM_THREADS-1:0] halt_hit;
  logic [NUM_THREADS-1:0] redir_hit;
  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] issue;
  tid_t                   last_tid;
  tid_t                   pref_tid;
  tid_t                   sel_tid;

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thread
    localparam tid_t  TID   = tid_t'(i);
    localparam word_t START = (i == 0) ? T0_START : T1_START;

    assign halt_hit[i]  = !reset && halt_req    && (halt_tid  == TID);
    assign redir_hit[i] = !reset && redir_valid && (redir_tid == TID);
    // A thread touched by halt or redirect this cycle sits out arbitration.
    assign elig[i]      = !halted_q[i] && !halt_hit[i] && !redir_hit[i];
    assign issue[i]     = fetch_valid && (sel_tid == TID);

    sched_thread_ctx #(
      .START_PC (START),
      .PC_STEP  (PC_STEP)
    ) u_ctx (
      .clk       (clk),
      .reset     (reset),
      .halt_set  (halt_hit[i]),
      .redir_set (redir_hit[i]),
      .redir_pc  (redir_pc),
      .issue     (issue[i]),
      .pc        (pc_q[i]),
      .halted    (halted_q[i])
    );
  end

  always_comb begin
    pref_tid = other_tid(last_tid);
    sel_tid  = last_tid;
    if (elig[pref_tid]) begin
      sel_tid = pref_tid;
    end
  end

  assign fetch_valid = !reset && !stall && (|elig);
  assign fetch_tid   = fetch_valid ? sel_tid : last_tid;
  assign fetch_pc    = pc_q[fetch_tid];

  // last_tid resets to 1 so that thread 0 is preferred on the first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_tid <= tid_t'(1);
    end else if (fetch_valid) begin
      last_tid <= sel_tid;
    end
  end

  assign halted = halted_q;
  assign halt   = !reset && (&halted_q);

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: directed scenarios with fixed expectations, then
// randomized traffic checked against an abstract scheduling model.
module tb_thread_scheduler;

  logic        clk = 1'b0;
  logic        reset, stall, halt_req, halt_tid, redir_valid, redir_tid;
  logic [15:0] redir_pc;
  logic        fetch_valid, fetch_tid, halt;
  logic [15:0] fetch_pc;
  logic [1:0]  halted;

  int checks   = 0;
  int failures = 0;

  bit [15:0] m_pc [2];
  bit        m_halted [2];
  bit        m_last;

  thread_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .halt_req    (halt_req),
    .halt_tid    (halt_tid),
    .redir_valid (redir_valid),
    .redir_tid   (redir_tid),
    .redir_pc    (redir_pc),
    .fetch_valid (fetch_valid),
    .fetch_tid   (fetch_tid),
    .fetch_pc    (fetch_pc),
    .halted      (halted),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  function automatic void model_eval(output bit fv, output bit tid, output bit [15:0] pc);
    bit el [2];
    bit pref;
    for (int t = 0; t < 2; t++)
      el[t] = !m_halted[t] && !(halt_req && halt_tid == t) && !(redir_valid && redir_tid == t);
    pref = !m_last;
    fv   = !reset && !stall && (el[0] || el[1]);
    tid  = m_last;
    if (fv) tid = el[pref] ? pref : m_last;
    pc   = m_pc[tid];
  endfunction

  function automatic void model_commit();
    bit        fv, tid;
    bit [15:0] pc;
    bit        redir_ok;
    if (reset) begin
      m_pc[0] = 16'h0000; m_pc[1] = 16'h0001;
      m_halted[0] = 0; m_halted[1] = 0;
      m_last = 1;
      return;
    end
    model_eval(fv, tid, pc);
    redir_ok = redir_valid && !m_halted[redir_tid] && !(halt_req && halt_tid == redir_tid);
    if (fv) begin
      m_pc[tid] = m_pc[tid] + 16'd2;
      m_last    = tid;
    end
    if (halt_req) m_halted[halt_tid] = 1;
    if (redir_ok) m_pc[redir_tid] = redir_pc;
  endfunction

  task automatic apply(input bit rst, input bit st, input bit hr, input bit ht,
                       input bit rv, input bit rt, input bit [15:0] rp);
    reset = rst; stall = st; halt_req = hr; halt_tid = ht;
    redir_valid = rv; redir_tid = rt; redir_pc = rp;
    #4;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 16'h0);
    tick();
  endtask

  task automatic test_reset();
    apply(1, 0, 1, 0, 1, 1, 16'h1234);
    checks++;
    if (fetch_valid !== 1'b0 || halt !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got fv=%b halt=%b want fv=0 halt=0", fetch_valid, halt);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    checks++;
    if (halted !== 2'b00 || halt !== 1'b0) begin
      failures++;
      $display("FAIL reset_halted got halted=%b halt=%b want 00/0", halted, halt);
    end
    checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== 1'b0 || fetch_pc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_first_fetch got v=%b tid=%0d pc=%h want v=1 tid=0 pc=0000",
               fetch_valid, fetch_tid, fetch_pc);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] epc  [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    logic        etid [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 0, 0, 0, 16'h0);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== etid[k] || fetch_pc !== epc[k]) begin
        failures++;
        $display("FAIL round_robin[%0d] got v=%b tid=%0d pc=%h want v=1 tid=%0d pc=%h",
                 k, fetch_valid, fetch_tid, fetch_pc, etid[k], epc[k]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [15:0] epc [5] = '{16'h0000, 16'h0001, 16'h0003, 16'h0005, 16'h0007};
    logic        etid [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(0, 0, (k == 1), 0, 0, 0, 16'h0);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== etid[k] || fetch_pc !== epc[k]) begin
        failures++;
        $display("FAIL halt_t0[%0d] got v=%b tid=%0d pc=%h want v=1 tid=%0d pc=%h",
                 k, fetch_valid, fetch_tid, fetch_pc, etid[k], epc[k]);
      end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    checks++;
    if (halted !== 2'b01 || halt !== 1'b0) begin
      failures++;
      $display("FAIL halt_t0_flags got halted=%b halt=%b want 01/0", halted, halt);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    tick();
    apply(0, 0, 0, 0, 1, 1, 16'h0040);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== 1'b0 || fetch_pc !== 16'h0002) begin
      failures++;
      $display("FAIL redir_cycle got v=%b tid=%0d pc=%h want v=1 tid=0 pc=0002",
               fetch_valid, fetch_tid, fetch_pc);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== 1'b1 || fetch_pc !== 16'h0040) begin
      failures++;
      $display("FAIL redir_target got v=%b tid=%0d pc=%h want v=1 tid=1 pc=0040",
               fetch_valid, fetch_tid, fetch_pc);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, (k == 1), 1, 0, 0, 16'h0);
      checks++;
      if (fetch_valid !== 1'b0 || fetch_tid !== 1'b0 || fetch_pc !== 16'h0002) begin
        failures++;
        $display("FAIL stall[%0d] got v=%b tid=%0d pc=%h want v=0 tid=0 pc=0002",
                 k, fetch_valid, fetch_tid, fetch_pc);
      end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    checks++;
    if (halted !== 2'b10) begin
      failures++;
      $display("FAIL stall_halt_flags got halted=%b want 10", halted);
    end
    for (int k = 0; k < 2; k++) begin
      apply(0, 0, 0, 0, 0, 0, 16'h0);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== 1'b0 || fetch_pc !== 16'h0002 + 16'(2 * k)) begin
        failures++;
        $display("FAIL stall_release[%0d] got v=%b tid=%0d pc=%h want v=1 tid=0 pc=%h",
                 k, fetch_valid, fetch_tid, fetch_pc, 16'h0002 + 16'(2 * k));
      end
      tick();
    end
  endtask

  task automatic test_wrap_and_halt_all();
    logic [15:0] epc  [4] = '{16'h0001, 16'hFFFE, 16'h0003, 16'h0000};
    logic        etid [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 0, (k == 0), 0, 16'hFFFE);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== etid[k] || fetch_pc !== epc[k]) begin
        failures++;
        $display("FAIL wrap[%0d] got v=%b tid=%0d pc=%h want v=1 tid=%0d pc=%h",
                 k, fetch_valid, fetch_tid, fetch_pc, etid[k], epc[k]);
      end
      tick();
    end
    apply(0, 0, 1, 0, 0, 0, 16'h0);
    tick();
    apply(0, 0, 1, 1, 0, 0, 16'h0);
    checks++;
    if (halt !== 1'b0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_all_pending got halt=%b fv=%b want 0/0", halt, fetch_valid);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    checks++;
    if (halt !== 1'b1 || halted !== 2'b11 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_all got halt=%b halted=%b fv=%b want 1/11/0", halt, halted, fetch_valid);
    end
    tick();
    apply(1, 0, 0, 0, 0, 0, 16'h0);
    checks++;
    if (halt !== 1'b0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_during_reset got halt=%b fv=%b want 0/0", halt, fetch_valid);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    checks++;
    if (halt !== 1'b0 || halted !== 2'b00 || fetch_tid !== 1'b0 || fetch_pc !== 16'h0000) begin
      failures++;
      $display("FAIL post_reset got halt=%b halted=%b tid=%0d pc=%h want 0/00/0/0000",
               halt, halted, fetch_tid, fetch_pc);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 16'h0);
    checks++;
    if (fetch_tid !== 1'b1 || fetch_pc !== 16'h0001) begin
      failures++;
      $display("FAIL post_reset_t1 got tid=%0d pc=%h want 1/0001", fetch_tid, fetch_pc);
    end
    tick();
  endtask

  task automatic test_random();
    bit        e_fv, e_tid, e_halt;
    bit [15:0] e_pc;
    bit [15:0] rp;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rp = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 11) == 0), 1'($urandom), ($urandom_range(0, 4) == 0),
            1'($urandom), rp);
      model_eval(e_fv, e_tid, e_pc);
      e_halt = !reset && m_halted[0] && m_halted[1];
      checks++;
      if (fetch_valid !== e_fv || fetch_tid !== e_tid || fetch_pc !== e_pc) begin
        failures++;
        $display("FAIL random_fetch[%0d] got v=%b tid=%0d pc=%h want v=%b tid=%0d pc=%h",
                 k, fetch_valid, fetch_tid, fetch_pc, e_fv, e_tid, e_pc);
      end
      checks++;
      if (halted !== {m_halted[1], m_halted[0]} || halt !== e_halt) begin
        failures++;
        $display("FAIL random_halt[%0d] got halted=%b halt=%b want halted=%b%b halt=%b",
                 k, halted, halt, m_halted[1], m_halted[0], e_halt);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1; stall = 0; halt_req = 0; halt_tid = 0;
    redir_valid = 0; redir_tid = 0; redir_pc = 16'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_halt();
    test_redirect();
    test_stall();
    test_wrap_and_halt_all();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
